// File: rtl/sonar_filter.sv
// sonar_filter: post-processing stage for the ultrasonic ranging block.
// Raw distances pass through an optional range clamp and then a
// 2^AVG_LOG2-sample moving-average window. The block publishes one filtered
// sample per accepted input, a hysteretic proximity alarm (NEAR) and a
// stale-sensor flag (STALE).
//
// Optional feature: define SONAR_FILTER_CLAMP_EN to clamp samples above
// MAX_DIST and to replace zero samples with the previous accepted sample.
// AVG_LOG2 must be at least 1.
module sonar_filter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned NEAR_TH  = 1000,
  parameter int unsigned HYST     = 100,
  parameter int unsigned TIMEOUT  = 50_000_000,
  parameter int unsigned MAX_DIST = 400_000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DIST_IN,
  input  logic             DIST_VALID,
  output logic [WIDTH-1:0] FILT_OUT,
  output logic             FILT_VALID,
  output logic             NEAR,
  output logic             STALE
);

  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = WIDTH + AVG_LOG2;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

`ifdef SONAR_FILTER_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX_CLAMP  = WIDTH'(MAX_DIST);
  localparam logic [WIDTH-1:0] SET_LEVEL  = WIDTH'(NEAR_TH);
  localparam logic [WIDTH-1:0] CLR_LEVEL  = WIDTH'(NEAR_TH + HYST);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [AVG_LOG2-1:0] FILL_LAST = AVG_LOG2'(DEPTH - 1);

  // Window state machine: FILL until the window holds DEPTH real samples.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [WIDTH-1:0]    r_buf [DEPTH];
  logic [SUM_W-1:0]    r_sum;
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [AVG_LOG2-1:0] r_fill_cnt;
  logic [0:0]          r_state;
  logic [IDLE_W-1:0]   r_idle;
  logic [WIDTH-1:0]    r_last;
  logic                r_have_last;

  logic [WIDTH-1:0]    w_sample;
  logic [SUM_W-1:0]    w_sum_next;
  logic [WIDTH-1:0]    w_avg;
  logic                w_emit;
  logic                w_timeout_hit;

  // Condition the incoming sample (clamp and zero substitution when enabled).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_sample = DIST_IN;
    if (CLAMP_EN) begin
      if (DIST_IN > MAX_CLAMP) begin
        w_sample = MAX_CLAMP;
      end else if ((DIST_IN == '0) && r_have_last) begin
        w_sample = r_last;
      end
    end
  end

  // Running-sum update, average and event decode for this cycle.
  always_comb begin
    w_sum_next    = r_sum - SUM_W'(r_buf[r_wr_ptr]) + SUM_W'(w_sample);
    w_avg         = w_sum_next[SUM_W-1:AVG_LOG2];
    w_emit        = DIST_VALID && ((r_state == ST_RUN) || (r_fill_cnt == FILL_LAST));
    // A sample arriving on the would-be timeout cycle wins over the timeout.
    w_timeout_hit = !DIST_VALID && (r_idle == IDLE_LAST);
  end

  // Window buffer, running sum, pointers and FILL/RUN state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the window buffer is reset (not left uninitialised) because the
      // running sum subtracts the slot being overwritten; stale garbage would
      // corrupt the average during the first fill.
      for (int i = 0; i < int'(DEPTH); i++) r_buf[i] <= '0;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_state     <= ST_FILL;
      r_last      <= '0;
      r_have_last <= 1'b0;
    end else if (DIST_VALID) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_buf[r_wr_ptr] <= w_sample;
      r_sum           <= w_sum_next;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
      r_last          <= w_sample;
      r_have_last     <= 1'b1;
      if (r_state == ST_FILL) begin
        r_fill_cnt <= r_fill_cnt + 1'b1;
        if (r_fill_cnt == FILL_LAST) begin
          r_state <= ST_RUN;
        end
      end
    end else if (w_timeout_hit) begin
      for (int i = 0; i < int'(DEPTH); i++) r_buf[i] <= '0;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_state     <= ST_FILL;
      r_have_last <= 1'b0;
    end
  end

  // Publish the filtered value; FILT_OUT holds between updates.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FILT_OUT   <= '0;
      FILT_VALID <= 1'b0;
    end else begin
      FILT_VALID <= w_emit;
      if (w_emit) begin
        FILT_OUT <= w_avg;
      end
    end
  end

  // Idle counter (saturating) and stale flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_idle <= '0;
      STALE  <= 1'b0;
    end else if (DIST_VALID) begin
      r_idle <= '0;
      STALE  <= 1'b0;
    end else begin
      if (r_idle != IDLE_MAX) begin
        r_idle <= r_idle + 1'b1;
      end
      if (w_timeout_hit) begin
        STALE <= 1'b1;
      end
    end
  end

  // Proximity alarm with hysteresis, judged on the published sample.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      NEAR <= 1'b0;
    end else if (w_timeout_hit) begin
      NEAR <= 1'b0;
    end else if (FILT_VALID) begin
      if (!NEAR && (FILT_OUT < SET_LEVEL)) begin
        NEAR <= 1'b1;
      end else if (NEAR && (FILT_OUT >= CLR_LEVEL)) begin
        NEAR <= 1'b0;
      end
    end
  end

endmodule
